// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-of-day controller with a run mode and a button-driven set mode.
// Holds hour/minute/second as binary registers and publishes them as packed BCD.
// Optional feature macro: CLOCK_SET_TIMEOUT_EN. When it is defined, a set state
// that sees TIMEOUT_S seconds without a button press falls back to run mode.
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [31:0] hms_hex,
  output logic [1:0]  edit_field,
  output logic        running
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [4:0] hour, hour_n;
  logic [5:0] minute, minute_n;
  logic [5:0] second, second_n;
  logic       adj_up, adj_down;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_S);
  logic [7:0] idle_cnt, idle_cnt_n;
`endif

  // Binary 0..59 to two BCD digits, tens in the upper nibble.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] units;
    tens  = v / 6'd10;
    units = v - tens * 6'd10;
    return {tens[3:0], units[3:0]};
  endfunction

  // Exactly one of inc/dec is an edit; both together cancel out.
  assign adj_up   = btn_inc & ~btn_dec;
  assign adj_down = btn_dec & ~btn_inc;

  // Next-state and next-time logic: counting in RUN, single-field edits in SET_x.
  always_comb begin
    state_n  = state;
    hour_n   = hour;
    minute_n = minute;
    second_n = second;
    case (state)
      RUN: begin
        if (tick_1hz) begin
          if (second == 6'd59) begin
            second_n = 6'd0;
            if (minute == 6'd59) begin
              minute_n = 6'd0;
              hour_n   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              minute_n = minute + 6'd1;
            end
          end else begin
            second_n = second + 6'd1;
          end
        end
        if (btn_mode) state_n = SET_H;
      end
      SET_H: begin
        if (btn_mode) state_n = SET_M;
        else if (adj_up) hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        else if (adj_down) hour_n = (hour == 5'd0) ? 5'd23 : hour - 5'd1;
      end
      SET_M: begin
        if (btn_mode) state_n = SET_S;
        else if (adj_up) minute_n = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        else if (adj_down) minute_n = (minute == 6'd0) ? 6'd59 : minute - 6'd1;
      end
      default: begin
        if (btn_mode) state_n = RUN;
        else if (adj_up) second_n = (second == 6'd59) ? 6'd0 : second + 6'd1;
        else if (adj_down) second_n = (second == 6'd0) ? 6'd59 : second - 6'd1;
      end
    endcase
`ifdef CLOCK_SET_TIMEOUT_EN
    // Counter holds the number of idle ticks seen so far; the tick that would
    // bring it to TIMEOUT_S ends the edit. Staying at zero in RUN gives a clean
    // start on entry to SET_H, and every button press restarts the wait.
    idle_cnt_n = idle_cnt;
    if (state == RUN) begin
      idle_cnt_n = 8'd0;
    end else if (btn_mode | btn_inc | btn_dec) begin
      idle_cnt_n = 8'd0;
    end else if (tick_1hz) begin
      if (idle_cnt + 8'd1 == TIMEOUT_LIM) begin
        state_n    = RUN;
        idle_cnt_n = 8'd0;
      end else begin
        idle_cnt_n = idle_cnt + 8'd1;
      end
    end
`endif
  end

  // State, time and decoded-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      hour       <= 5'd0;
      minute     <= 6'd0;
      second     <= 6'd0;
      edit_field <= 2'd0;
      running    <= 1'b1;
    end else begin
      state      <= state_n;
      hour       <= hour_n;
      minute     <= minute_n;
      second     <= second_n;
      edit_field <= state_n;
      running    <= (state_n == RUN);
    end
  end

`ifdef CLOCK_SET_TIMEOUT_EN
  // Inactivity counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= 8'd0;
    else        idle_cnt <= idle_cnt_n;
  end
`endif

  // Display word lags the time registers by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hms_hex <= 32'h0000_0000;
    else        hms_hex <= {8'h00, to_bcd({1'b0, hour}), to_bcd(minute), to_bcd(second)};
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: behavioural time-of-day model feeding a
// scoreboard queue of expected {running, edit_field, hms_hex} words.
module tb_clock_set_ctrl;

  localparam int TO = 3;

  logic        clk;
  logic        rst_n;
  logic        tick_1hz;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [31:0] hms_hex;
  logic [1:0]  edit_field;
  logic        running;

  int total = 0;
  int bad   = 0;

  int m_h, m_m, m_s, m_st, m_cnt;
  logic [34:0] exp_q[$];

  clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .hms_hex   (hms_hex),
    .edit_field(edit_field),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [31:0] model_hms();
    return {8'h00, bcd(m_h), bcd(m_m), bcd(m_s)};
  endfunction

  // One clock of the reference behaviour for the given sampled inputs.
  task automatic model_step(input logic m, input logic i, input logic d, input logic t);
    int old_st;
    old_st = m_st;
    if (old_st == 0) begin
      if (t) begin
        m_s = m_s + 1;
        if (m_s == 60) begin m_s = 0; m_m = m_m + 1; end
        if (m_m == 60) begin m_m = 0; m_h = m_h + 1; end
        if (m_h == 24) m_h = 0;
      end
      if (m) m_st = 1;
    end else if (m) begin
      m_st = (old_st == 3) ? 0 : old_st + 1;
    end else if (i && !d) begin
      if (old_st == 1) m_h = (m_h + 1) % 24;
      if (old_st == 2) m_m = (m_m + 1) % 60;
      if (old_st == 3) m_s = (m_s + 1) % 60;
    end else if (d && !i) begin
      if (old_st == 1) m_h = (m_h + 23) % 24;
      if (old_st == 2) m_m = (m_m + 59) % 60;
      if (old_st == 3) m_s = (m_s + 59) % 60;
    end
`ifdef CLOCK_SET_TIMEOUT_EN
    if (old_st == 0) m_cnt = 0;
    else if (m || i || d) m_cnt = 0;
    else if (t) begin
      if (m_cnt + 1 == TO) begin m_st = 0; m_cnt = 0; end
      else m_cnt = m_cnt + 1;
    end
`endif
  endtask

  task automatic push_expected();
    exp_q.push_back({(m_st == 0), 2'(m_st), model_hms()});
  endtask

  // Drives the same input pattern for n consecutive cycles, then idles.
  task automatic applyStimulus(input logic m, input logic i, input logic d,
                               input logic t, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      btn_mode = m; btn_inc = i; btn_dec = d; tick_1hz = t;
      model_step(m, i, d, t);
    end
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
    push_expected();
  endtask

  // Pops one scoreboard entry once the display register has caught up.
  task automatic checkOutput(input string name);
    logic [34:0] e;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, got hms_hex=%h", name, hms_hex);
    end else begin
      e = exp_q.pop_front();
      if (hms_hex !== e[31:0]) begin
        bad++;
        $display("[TB] FAIL %s hms_hex: got %h want %h", name, hms_hex, e[31:0]);
      end
      total++;
      if (edit_field !== e[33:32]) begin
        bad++;
        $display("[TB] FAIL %s edit_field: got %0d want %0d", name, edit_field, e[33:32]);
      end
      total++;
      if (running !== e[34]) begin
        bad++;
        $display("[TB] FAIL %s running: got %b want %b", name, running, e[34]);
      end
    end
  endtask

  task automatic op(input string name, input logic m, input logic i, input logic d,
                    input logic t, input int n);
    applyStimulus(m, i, d, t, n);
    checkOutput(name);
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
    rst_n = 0;
    model_reset();
    #17;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge clk);
    total++;
    if (hms_hex !== 32'h0) begin bad++; $display("[TB] FAIL reset hms_hex: got %h want 00000000", hms_hex); end
    total++;
    if (edit_field !== 2'd0) begin bad++; $display("[TB] FAIL reset edit_field: got %0d want 0", edit_field); end
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL reset running: got %b want 1", running); end
  endtask

  task automatic test_run_count();
    logic [31:0] prev;
    do_reset();
    op("run61", 0, 0, 0, 1, 61);
    total++;
    if (hms_hex !== 32'h0000_0101) begin bad++; $display("[TB] FAIL run61 const: got %h want 00000101", hms_hex); end
    prev = model_hms();
    @(negedge clk);
    tick_1hz = 1;
    model_step(0, 0, 0, 1);
    @(negedge clk);
    tick_1hz = 0;
    total++;
    if (hms_hex !== prev) begin bad++; $display("[TB] FAIL latency early: got %h want %h", hms_hex, prev); end
    push_expected();
    checkOutput("latency late");
  endtask

  task automatic test_wrap();
    do_reset();
    op("wrap mode1", 1, 0, 0, 0, 1);
    op("wrap hdec", 0, 0, 1, 0, 1);
    op("wrap mode2", 1, 0, 0, 0, 1);
    op("wrap mdec", 0, 0, 1, 0, 1);
    op("wrap mode3", 1, 0, 0, 0, 1);
    op("wrap sdec", 0, 0, 1, 0, 1);
    op("wrap torun", 1, 0, 0, 0, 1);
    total++;
    if (hms_hex !== 32'h0023_5959) begin bad++; $display("[TB] FAIL wrap preload: got %h want 00235959", hms_hex); end
    op("wrap tick", 0, 0, 0, 1, 1);
    total++;
    if (hms_hex !== 32'h0) begin bad++; $display("[TB] FAIL wrap midnight: got %h want 00000000", hms_hex); end
  endtask

  task automatic test_set_hour();
    do_reset();
    op("seth enter", 1, 0, 0, 0, 1);
    op("seth dec0", 0, 0, 1, 0, 1);
    total++;
    if (hms_hex[23:16] !== 8'h23) begin bad++; $display("[TB] FAIL seth hour: got %h want 23", hms_hex[23:16]); end
    op("seth inc", 0, 1, 0, 0, 1);
    op("seth dec", 0, 0, 1, 0, 1);
    op("seth ticks100", 0, 0, 0, 1, 100);
  endtask

  task automatic test_set_min();
    do_reset();
    op("setm enter1", 1, 0, 0, 0, 1);
    op("setm enter2", 1, 0, 0, 0, 1);
    op("setm dec0", 0, 0, 1, 0, 1);
    op("setm inc59", 0, 1, 0, 0, 1);
    op("setm inc", 0, 1, 0, 0, 3);
    op("setm both", 0, 1, 1, 0, 1);
    op("setm mode+inc", 1, 1, 0, 0, 1);
    op("sets inc", 0, 1, 0, 0, 1);
    op("sets dec0", 0, 0, 1, 0, 2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    op("b2b ticks", 0, 0, 0, 1, 5);
    op("b2b mode+tick run", 1, 0, 0, 1, 1);
    op("b2b to setm", 1, 0, 0, 0, 1);
    op("b2b to sets", 1, 0, 0, 0, 1);
    op("b2b mode+tick sets", 1, 0, 0, 1, 1);
    op("b2b resume", 0, 0, 0, 1, 1);
    op("b2b random", 0, 0, 0, 1, 1 + $urandom_range(0, 20));
  endtask

  task automatic test_async_reset();
    do_reset();
    op("ar ticks", 0, 0, 0, 1, 7);
    op("ar seth", 1, 0, 0, 0, 1);
    op("ar hinc", 0, 1, 0, 0, 4);
    op("ar setm", 1, 0, 0, 0, 1);
    op("ar sets", 1, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    total++;
    if (hms_hex !== 32'h0) begin bad++; $display("[TB] FAIL async hms_hex: got %h want 00000000", hms_hex); end
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL async running: got %b want 1", running); end
    total++;
    if (edit_field !== 2'd0) begin bad++; $display("[TB] FAIL async edit_field: got %0d want 0", edit_field); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_timeout();
    do_reset();
    op("to enter", 1, 0, 0, 0, 1);
`ifdef CLOCK_SET_TIMEOUT_EN
    op("to t1", 0, 0, 0, 1, 1);
    op("to t2", 0, 0, 0, 1, 1);
    op("to t3", 0, 0, 0, 1, 1);
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL to expire: got running=%b want 1", running); end
    op("to reenter", 1, 0, 0, 0, 1);
    op("to r1", 0, 0, 0, 1, 1);
    op("to r2", 0, 0, 0, 1, 1);
    op("to inc", 0, 1, 0, 0, 1);
    op("to r3", 0, 0, 0, 1, 1);
    total++;
    if (edit_field !== 2'd1) begin bad++; $display("[TB] FAIL to held: got edit_field=%0d want 1", edit_field); end
    op("to a2", 0, 0, 0, 1, 1);
    op("to a3", 0, 0, 0, 1, 1);
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL to expire2: got running=%b want 1", running); end
`else
    op("to ticks300", 0, 0, 0, 1, 300);
    total++;
    if (edit_field !== 2'd1) begin bad++; $display("[TB] FAIL to persist: got edit_field=%0d want 1", edit_field); end
`endif
  endtask

  initial begin
    rst_n = 0;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
    test_reset();
    test_run_count();
    test_wrap();
    test_set_hour();
    test_set_min();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
